pong_game_ctrl: RTL and testbench

Top-level game sequencer for Pong. It owns the per-player life counters and the title → play → serve-wait → game-over state machine. It freezes and re-serves the ball through the graphics path and tells the text renderer which text regions to show. It sits between the debounced buttons, the ball/paddle graphics block (miss pulses, frame tick) and the text renderer (lives, region mask).

---
 rtl/pong_pkg.sv | 29 ++
 rtl/pong_game_ctrl_frame_timer.sv | 26 ++
 rtl/pong_game_ctrl.sv | 110 +++++++++++
 tb/tb_pong_game_ctrl.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/pong_pkg.sv
// pong_pkg: shared states, text-region bit positions and winner codes for the pong sequencer.
package pong_pkg;

    typedef enum logic [1:0] {NEWGAME, PLAY, SERVE, OVER} state_t;

    localparam int TXT_P1   = 5;
    localparam int TXT_P2   = 4;
    localparam int TXT_LOGO = 3;
    localparam int TXT_RULE = 2;
    localparam int TXT_OVER = 1;

    localparam logic [1:0] WIN_NONE = 2'b00;
    localparam logic [1:0] WIN_P1   = 2'b01;
    localparam logic [1:0] WIN_P2   = 2'b10;
    localparam logic [1:0] WIN_DRAW = 2'b11;

    // Scores are always visible; the title and game-over text depend on the state.
    function automatic logic [5:0] mask_of(input state_t s);
        logic [5:0] m;
        m = '0;
        m[TXT_P1] = 1'b1;
        m[TXT_P2] = 1'b1;
        m[TXT_LOGO] = (s == NEWGAME);
        m[TXT_RULE] = (s == NEWGAME);
        m[TXT_OVER] = (s == OVER);
        return m;
    endfunction

endpackage

// File: rtl/pong_game_ctrl_frame_timer.sv
// frame_timer: down-counter of frame ticks; expire fires on the tick that would take it from 1 to 0.
module frame_timer #(
    parameter int W = 7
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         tick,
    output logic         expire
);
    logic [W-1:0] count;

    // Load wins over a coincident tick so the entry cycle is never counted.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            count <= '0;
        else if (load)
            count <= load_val;
        else if (tick && count != '0)
            count <= count - 1'b1;
    end

    assign expire = tick & (count == W'(1));

endmodule

// File: rtl/pong_game_ctrl.sv
// pong_game_ctrl: title/play/serve/game-over sequencer owning both life counters,
// ball freeze/recentre control and the text-region mask.
module pong_game_ctrl
    import pong_pkg::*;
#(
    parameter int LIVES       = 3,
    parameter int WAIT_FRAMES = 120
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       refr_tick,
    input  logic [1:0] btn,
    input  logic       miss1,
    input  logic       miss2,
    output logic [1:0] lives1,
    output logic [1:0] lives2,
    output logic       graph_still,
    output logic       ball_reset,
    output logic [5:0] text_mask,
    output logic [1:0] winner
);
    localparam int TW = $clog2(WAIT_FRAMES + 1);
    localparam logic [TW-1:0] WAIT_VAL = TW'(WAIT_FRAMES);
    localparam logic [1:0] LIVES_VAL = 2'(LIVES);

    state_t     state;
    logic [1:0] btn_q;
    logic       press;
    logic       miss;
    logic       load;
    logic       expire;
    logic [1:0] next1;
    logic [1:0] next2;

    assign press = |(btn & ~btn_q);
    assign miss  = miss1 | miss2;
    assign next1 = (miss1 && lives1 != 2'd0) ? lives1 - 2'd1 : lives1;
    assign next2 = (miss2 && lives2 != 2'd0) ? lives2 - 2'd1 : lives2;
    // SERVE and OVER are only ever entered from PLAY on a miss.
    assign load  = (state == PLAY) & miss;

    frame_timer #(.W(TW)) u_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (load),
        .load_val (WAIT_VAL),
        .tick     (refr_tick),
        .expire   (expire)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= NEWGAME;
            btn_q       <= 2'b00;
            lives1      <= LIVES_VAL;
            lives2      <= LIVES_VAL;
            graph_still <= 1'b1;
            ball_reset  <= 1'b0;
            text_mask   <= mask_of(NEWGAME);
            winner      <= WIN_NONE;
        end else begin
            btn_q      <= btn;
            ball_reset <= 1'b0;
            case (state)
                NEWGAME: begin
                    if (press) begin
                        state       <= PLAY;
                        graph_still <= 1'b0;
                        ball_reset  <= 1'b1;
                        text_mask   <= mask_of(PLAY);
                    end
                end
                PLAY: begin
                    if (miss) begin
                        lives1      <= next1;
                        lives2      <= next2;
                        graph_still <= 1'b1;
                        if (next1 == 2'd0 || next2 == 2'd0) begin
                            state     <= OVER;
                            text_mask <= mask_of(OVER);
                            winner    <= (next1 != 2'd0) ? WIN_P1 :
                                         (next2 != 2'd0) ? WIN_P2 : WIN_DRAW;
                        end else begin
                            state     <= SERVE;
                            text_mask <= mask_of(SERVE);
                        end
                    end
                end
                SERVE: begin
                    if (expire) begin
                        state       <= PLAY;
                        graph_still <= 1'b0;
                        ball_reset  <= 1'b1;
                        text_mask   <= mask_of(PLAY);
                    end
                end
                OVER: begin
                    if (expire) begin
                        state     <= NEWGAME;
                        lives1    <= LIVES_VAL;
                        lives2    <= LIVES_VAL;
                        winner    <= WIN_NONE;
                        text_mask <= mask_of(NEWGAME);
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pong_game_ctrl.sv
// tb_pong_game_ctrl: directed vectors with hand-computed expectations for the pong sequencer.
module tb_pong_game_ctrl;
    localparam int WF = 120;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       refr_tick;
    logic [1:0] btn;
    logic       miss1;
    logic       miss2;
    logic [1:0] lives1;
    logic [1:0] lives2;
    logic       graph_still;
    logic       ball_reset;
    logic [5:0] text_mask;
    logic [1:0] winner;

    int total = 0;
    int bad = 0;

    pong_game_ctrl #(.LIVES(3), .WAIT_FRAMES(WF)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .refr_tick   (refr_tick),
        .btn         (btn),
        .miss1       (miss1),
        .miss2       (miss2),
        .lives1      (lives1),
        .lives2      (lives2),
        .graph_still (graph_still),
        .ball_reset  (ball_reset),
        .text_mask   (text_mask),
        .winner      (winner)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic miss(input logic m1, input logic m2);
        miss1 = m1;
        miss2 = m2;
        cyc();
        miss1 = 1'b0;
        miss2 = 1'b0;
    endtask

    task automatic ticks(input int n);
        repeat (n) begin
            refr_tick = 1'b1;
            cyc();
            refr_tick = 1'b0;
            cyc();
        end
    endtask

    task automatic press(input logic [1:0] b);
        btn = b;
        cyc();
        btn = 2'b00;
    endtask

    // Last serve tick: must release the ball with a recentre pulse.
    task automatic final_tick_to_play(input string tag);
        refr_tick = 1'b1;
        cyc();
        refr_tick = 1'b0;
        chk({tag, "_br"}, 8'(ball_reset), 8'd1);
        chk({tag, "_still"}, 8'(graph_still), 8'd0);
        cyc();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1);
    end

    initial begin
        int pulses;
        rst_n = 1'b0;
        refr_tick = 1'b0;
        btn = 2'b00;
        miss1 = 1'b0;
        miss2 = 1'b0;
        repeat (3) cyc();
        chk("rst_l1", 8'(lives1), 8'd3);
        chk("rst_l2", 8'(lives2), 8'd3);
        chk("rst_still", 8'(graph_still), 8'd1);
        chk("rst_br", 8'(ball_reset), 8'd0);
        chk("rst_mask", 8'(text_mask), 8'b111100);
        chk("rst_win", 8'(winner), 8'd0);
        rst_n = 1'b1;
        miss(1'b1, 1'b0);
        chk("title_miss_l1", 8'(lives1), 8'd3);
        chk("title_mask", 8'(text_mask), 8'b111100);

        btn = 2'b01;
        cyc();
        chk("start_br", 8'(ball_reset), 8'd1);
        chk("start_still", 8'(graph_still), 8'd0);
        chk("start_mask", 8'(text_mask), 8'b110000);
        pulses = 0;
        repeat (4) begin
            cyc();
            pulses += int'(ball_reset);
        end
        chk("held_btn_pulses", 8'(pulses), 8'd0);
        btn = 2'b00;

        miss(1'b1, 1'b0);
        chk("m1_l1", 8'(lives1), 8'd2);
        chk("m1_l2", 8'(lives2), 8'd3);
        chk("m1_still", 8'(graph_still), 8'd1);
        chk("m1_mask", 8'(text_mask), 8'b110000);
        ticks(60);
        miss(1'b1, 1'b0);
        chk("serve_miss_l1", 8'(lives1), 8'd2);
        press(2'b10);
        chk("serve_btn_still", 8'(graph_still), 8'd1);
        ticks(WF - 61);
        chk("serve_119_still", 8'(graph_still), 8'd1);
        chk("serve_119_br", 8'(ball_reset), 8'd0);
        final_tick_to_play("serve1");
        chk("serve1_br_clear", 8'(ball_reset), 8'd0);

        for (int i = 0; i < 3; i++) begin
            refr_tick = (i == 0);
            miss(1'b0, 1'b1);
            refr_tick = 1'b0;
            chk($sformatf("m2_%0d_l2", i), 8'(lives2), 8'(2 - i));
            chk($sformatf("m2_%0d_l1", i), 8'(lives1), 8'd2);
            if (i < 2) begin
                ticks(WF - 1);
                chk($sformatf("m2_%0d_wait_still", i), 8'(graph_still), 8'd1);
                final_tick_to_play($sformatf("m2_%0d", i));
            end
        end
        chk("over_win", 8'(winner), 8'b01);
        chk("over_mask", 8'(text_mask), 8'b110010);
        chk("over_still", 8'(graph_still), 8'd1);

        miss(1'b1, 1'b0);
        chk("over_miss_l1", 8'(lives1), 8'd2);
        press(2'b01);
        chk("over_btn_mask", 8'(text_mask), 8'b110010);
        chk("over_btn_br", 8'(ball_reset), 8'd0);
        ticks(WF - 1);
        chk("over_119_mask", 8'(text_mask), 8'b110010);
        chk("over_119_win", 8'(winner), 8'b01);
        refr_tick = 1'b1;
        cyc();
        refr_tick = 1'b0;
        chk("over_end_mask", 8'(text_mask), 8'b111100);
        chk("over_end_l1", 8'(lives1), 8'd3);
        chk("over_end_l2", 8'(lives2), 8'd3);
        chk("over_end_win", 8'(winner), 8'd0);
        chk("over_end_still", 8'(graph_still), 8'd1);
        chk("over_end_br", 8'(ball_reset), 8'd0);

        press(2'b10);
        chk("g2_br", 8'(ball_reset), 8'd1);
        for (int i = 0; i < 2; i++) begin
            miss(1'b1, 1'b0);
            ticks(WF);
            miss(1'b0, 1'b1);
            ticks(WF);
        end
        chk("g2_l1", 8'(lives1), 8'd1);
        chk("g2_l2", 8'(lives2), 8'd1);
        chk("g2_play_still", 8'(graph_still), 8'd0);
        miss(1'b1, 1'b1);
        chk("draw_l1", 8'(lives1), 8'd0);
        chk("draw_l2", 8'(lives2), 8'd0);
        chk("draw_win", 8'(winner), 8'b11);
        chk("draw_mask", 8'(text_mask), 8'b110010);
        ticks(WF);
        chk("draw_end_mask", 8'(text_mask), 8'b111100);

        press(2'b01);
        miss(1'b1, 1'b0);
        ticks(WF - 50);
        chk("pre_rst_l1", 8'(lives1), 8'd2);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_l1", 8'(lives1), 8'd3);
        chk("async_mask", 8'(text_mask), 8'b111100);
        chk("async_still", 8'(graph_still), 8'd1);
        chk("async_win", 8'(winner), 8'd0);
        cyc();
        rst_n = 1'b1;
        cyc();
        press(2'b01);
        chk("post_rst_br", 8'(ball_reset), 8'd1);
        chk("post_rst_still", 8'(graph_still), 8'd0);
        chk("post_rst_l1", 8'(lives1), 8'd3);
        chk("post_rst_l2", 8'(lives2), 8'd3);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
